// File: rtl/yarv_pkg.sv
// Shared types and constants for the yarv fetch front end.
package yarv_pkg;

    localparam logic [31:0] NOP_INSN         = 32'h00000013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h00000000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        TRAP
    } fetch_state_t;

    function automatic logic is_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO holding fetched words with their PCs; DEPTH must be a power of two.
module fetch_buffer
    import yarv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  fetch_entry_t  din,
    input  logic          pop,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign head    = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is not reset; count/empty guard every read, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding imem read, prefetch FIFO, redirect and trap handling.
// Define FETCH_BYPASS_EN to forward a response straight to insn/pc when the FIFO is empty.
module fetch
    import yarv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        override,
    input  logic [31:0] newpc,
    input  logic        fault,
    output logic        imem_valid,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] insn,
    output logic [31:0] pc,
    output logic        insn_valid,
    output logic        trap
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t  state;
    logic [31:0]   fpc;
    logic [31:0]   next_fpc;
    logic          drop;
    fetch_entry_t  head;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          resp, go_trap, redirect, flush, bypass, push, pop, space;

    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        resp     = imem_valid && imem_ready;
        go_trap  = fault || (override && !is_aligned(newpc));
        redirect = override && !go_trap;
        flush    = override || fault;
`ifdef FETCH_BYPASS_EN
        bypass   = empty && resp && !drop && (state != TRAP);
`else
        bypass   = 1'b0;
`endif
        insn_valid = !empty || bypass;
        insn       = bypass ? imem_rdata : (!empty ? head.insn : NOP_INSN);
        pc         = bypass ? fpc        : (!empty ? head.pc   : fpc);
        pop        = !empty && !stall && !override;
        // A bypassed word that is consumed immediately never enters the FIFO.
        push       = resp && !drop && !flush && (state != TRAP) && (!full || pop)
                     && !(bypass && !stall);
        count_next = flush ? '0 : count + CW'(push) - CW'(pop);
        space      = count_next < CW'(DEPTH);
        next_fpc   = drop ? fpc : fpc + 32'd4;
    end

    fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .din   ('{pc: fpc, insn: imem_rdata}),
        .pop   (pop),
        .flush (flush),
        .full  (full),
        .empty (empty),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            fpc        <= RESET_PC;
            drop       <= 1'b0;
            imem_valid <= 1'b0;
            imem_addr  <= RESET_PC;
            trap       <= 1'b0;
        end else if (state == TRAP) begin
            // An in-flight read must still finish its handshake; nothing new is issued.
            if (resp) imem_valid <= 1'b0;
        end else if (go_trap) begin
            state <= TRAP;
            trap  <= 1'b1;
            if (resp) imem_valid <= 1'b0;
        end else if (redirect) begin
            fpc <= newpc;
            if (imem_valid && !imem_ready) begin
                drop <= 1'b1;
            end else begin
                drop       <= 1'b0;
                state      <= REQ;
                imem_valid <= 1'b1;
                imem_addr  <= newpc;
            end
        end else if (resp) begin
            drop <= 1'b0;
            fpc  <= next_fpc;
            if (space) begin
                state      <= REQ;
                imem_valid <= 1'b1;
                imem_addr  <= next_fpc;
            end else begin
                state      <= IDLE;
                imem_valid <= 1'b0;
            end
        end else if (state == IDLE && space) begin
            state      <= REQ;
            imem_valid <= 1'b1;
            imem_addr  <= fpc;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: directed stream, stall, redirect, trap, fault and async reset.
module tb_fetch;
    import yarv_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        stall = 1'b0;
    logic        override = 1'b0;
    logic [31:0] newpc = '0;
    logic        fault = 1'b0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic [31:0] insn;
    logic [31:0] pc;
    logic        insn_valid;
    logic        trap;

    fetch #(.RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .stall      (stall),
        .override   (override),
        .newpc      (newpc),
        .fault      (fault),
        .imem_valid (imem_valid),
        .imem_ready (imem_ready),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .insn       (insn),
        .pc         (pc),
        .insn_valid (insn_valid),
        .trap       (trap)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int consumed = 0;
    int ready_delay = 0;
    fetch_entry_t exp_q[$];
    logic [31:0]  addr_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h1000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic expect_pc(input logic [31:0] a);
        exp_q.push_back('{pc: a, insn: mem_word(a)});
    endtask

    task automatic wait_consumed(input int target, input int budget);
        int n = 0;
        while (consumed < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (consumed >= target) passed++;
        else $display("FAIL wait_consumed: got %0d expected %0d", consumed, target);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // Memory model: answers after ready_delay idle cycles and checks the request is held.
    int          wait_cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    always @(posedge clk) begin
        #2;
        if (!rstn) begin
            imem_ready = 1'b0;
            wait_cnt   = 0;
            pend       = 1'b0;
        end else begin
            if (pend) begin
                check("hold_valid", {31'b0, imem_valid}, 32'd1);
                check("hold_addr", imem_addr, pend_addr);
            end
            if (!imem_valid) begin
                imem_ready = 1'b0;
                wait_cnt   = 0;
            end else if (wait_cnt >= ready_delay) begin
                imem_ready = 1'b1;
                imem_rdata = mem_word(imem_addr);
                addr_log.push_back(imem_addr);
                wait_cnt   = 0;
            end else begin
                imem_ready = 1'b0;
                wait_cnt++;
            end
            pend      = imem_valid && !imem_ready;
            pend_addr = imem_addr;
        end
    end

    // Monitor: every word the downstream stage accepts must match the next expected entry.
    fetch_entry_t mon_e;
    always @(negedge clk) begin
        if (rstn && insn_valid && !stall && !override) begin
            consumed++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_insn: got pc %h expected none", pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_pc", pc, mon_e.pc);
                check("sb_insn", insn, mon_e.insn);
            end
        end
    end

    int valid_seen;
    int hits;
    int base;
    int n;

    initial begin
        #1 rstn = 1'b0;
        #1;
        check("rst_insn_valid", {31'b0, insn_valid}, 32'd0);
        check("rst_imem_valid", {31'b0, imem_valid}, 32'd0);
        check("rst_trap", {31'b0, trap}, 32'd0);
        check("rst_insn", insn, NOP_INSN);
        check("rst_pc", pc, 32'h0);
        @(posedge clk); @(posedge clk); #1 rstn = 1'b1;

        // Stream, stall with a full FIFO, then redirect over a pending read of 0x10.
        expect_pc(32'h0);   expect_pc(32'h4);   expect_pc(32'h8);   expect_pc(32'hC);
        expect_pc(32'h100); expect_pc(32'h104); expect_pc(32'h108);
        wait_consumed(2, 20);
        stall = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("full_no_req", {31'b0, imem_valid}, 32'd0);
        check("full_head_valid", {31'b0, insn_valid}, 32'd1);
        check("full_head_pc", pc, 32'h8);
        check("full_fetch_count", addr_log.size(), 32'd4);
        repeat (2) @(posedge clk); #1;
        stall = 1'b0;
        ready_delay = 3;
        wait_consumed(4, 20);
        check("pending_valid", {31'b0, imem_valid}, 32'd1);
        check("pending_addr", imem_addr, 32'h10);
        override = 1'b1;
        newpc = 32'h100;
        @(posedge clk); #1;
        override = 1'b0;
        wait_consumed(7, 100);
        stall = 1'b1;
        check("sb_drained", exp_q.size(), 32'd0);
        check("addr_dropped", addr_log[4], 32'h10);
        check("addr_redirect", addr_log[5], 32'h100);

        // Misaligned redirect while idle with a full FIFO.
        repeat (20) @(posedge clk); #1;
        check("pre_trap", {31'b0, trap}, 32'd0);
        check("idle_full", {31'b0, imem_valid}, 32'd0);
        override = 1'b1;
        newpc = 32'h102;
        @(posedge clk); #1;
        override = 1'b0;
        check("mis_trap", {31'b0, trap}, 32'd1);
        check("mis_imem_valid", {31'b0, imem_valid}, 32'd0);
        check("mis_insn_valid", {31'b0, insn_valid}, 32'd0);
        check("mis_insn", insn, NOP_INSN);
        valid_seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (imem_valid) valid_seen++;
        end
        check("mis_no_fetch", valid_seen, 32'd0);
        check("mis_trap_held", {31'b0, trap}, 32'd1);
        stall = 1'b0;

        // Fault and override together: trap wins, newpc is never fetched.
        do_reset();
        ready_delay = 0;
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
        base = consumed;
        wait_consumed(base + 3, 30);
        fault = 1'b1;
        override = 1'b1;
        newpc = 32'h200;
        @(posedge clk); #1;
        fault = 1'b0;
        override = 1'b0;
        check("flt_trap", {31'b0, trap}, 32'd1);
        check("flt_insn_valid", {31'b0, insn_valid}, 32'd0);
        check("flt_imem_valid", {31'b0, imem_valid}, 32'd0);
        valid_seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (imem_valid) valid_seen++;
        end
        check("flt_no_fetch", valid_seen, 32'd0);
        hits = 0;
        foreach (addr_log[i]) if (addr_log[i] == 32'h200) hits++;
        check("flt_newpc_unfetched", hits, 32'd0);
        check("flt_sb_drained", exp_q.size(), 32'd0);

        // Asynchronous reset in the middle of a pending request.
        do_reset();
        ready_delay = 3;
        n = 0;
        while (!imem_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("pre_reset_req", {31'b0, imem_valid}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("arst_imem_valid", {31'b0, imem_valid}, 32'd0);
        check("arst_insn_valid", {31'b0, insn_valid}, 32'd0);
        check("arst_trap", {31'b0, trap}, 32'd0);
        check("arst_insn", insn, NOP_INSN);
        check("arst_pc", pc, 32'h0);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
